// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wb_pkg;

   // Arbiter FSM: empty hold buffer, buffered MDU result, forced drain.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_PEND  = 2'd1,
      S_FORCE = 2'd2
   } wb_state_e;

   // Writes to x0 are never requests.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Default number of denied cycles before the buffered result is forced.
   localparam int MAX_WAIT_DEF = 4;

   // Width of the starvation counter (MAX_WAIT is limited to 1..15).
   localparam int CNT_W = 4;

endpackage

// File: rtl/wb_hold_reg.sv
// One-entry hold buffer for an MDU result displaced by the pipeline.
module wb_hold_reg #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [ADDR_W-1:0] wr_i,
   input  logic [DATA_W-1:0] wd_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] wr_o,
   output logic [DATA_W-1:0] wd_o
);

   logic              valid_q;
   logic [ADDR_W-1:0] wr_q;
   logic [DATA_W-1:0] wd_q;

   // Capture on load (wins over clear); clear only drops the valid flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         wr_q    <= '0;
         wd_q    <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         wr_q    <= wr_i;
         wd_q    <= wd_i;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign wr_o    = wr_q;
   assign wd_o    = wd_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, a displaced
// MDU result is parked in a one-entry buffer and forced through after
// MAX_WAIT denied cycles by stalling WB for one cycle.
//
// MDU handshake: a result transfers on a cycle where mdu_valid && mdu_ready
// are both high; mdu_ready is high only while the buffer is empty and reset
// is low. A transferred result for x0 is accepted and discarded.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_we,
   input  logic [ADDR_W-1:0] pipe_wr,
   input  logic [DATA_W-1:0] pipe_wd,
   input  logic              mdu_valid,
   output logic              mdu_ready,
   input  logic [ADDR_W-1:0] mdu_wr,
   input  logic [DATA_W-1:0] mdu_wd,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wr,
   output logic [DATA_W-1:0] rf_wd,
   output logic              wb_stall,
   output logic              pend_valid,
   output logic [ADDR_W-1:0] pend_wr
);

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_WAIT - 1);

   wb_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              hold_load, hold_clear;
   logic              hold_valid;
   logic [ADDR_W-1:0] hold_wr;
   logic [DATA_W-1:0] hold_wd;
   logic              pipe_req, mdu_req;

   assign pipe_req = pipe_we   && (pipe_wr != ZERO_IDX);
   assign mdu_req  = mdu_valid && (mdu_wr  != ZERO_IDX);

   wb_hold_reg #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_hold (
      .clk     (clk),
      .rst     (rst),
      .load_i  (hold_load),
      .clear_i (hold_clear),
      .wr_i    (mdu_wr),
      .wd_i    (mdu_wd),
      .valid_o (hold_valid),
      .wr_o    (hold_wr),
      .wd_o    (hold_wd)
   );

   // State and starvation counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_EMPTY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, counter update and hold-buffer load/clear.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hold_load  = 1'b0;
      hold_clear = 1'b0;
      case (state_q)
         S_EMPTY: begin
            // Same-register collision: the younger pipeline write wins.
            if (pipe_req && mdu_req && (mdu_wr != pipe_wr)) begin
               hold_load = 1'b1;
               cnt_d     = '0;
               state_d   = S_PEND;
            end
         end
         S_PEND: begin
            // Drain when the port is free, or drop a result made stale by WAW.
            if (!pipe_req || (pipe_wr == hold_wr)) begin
               hold_clear = 1'b1;
               cnt_d      = '0;
               state_d    = S_EMPTY;
            end else begin
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) state_d = S_FORCE;
            end
         end
         S_FORCE: begin
            hold_clear = 1'b1;
            cnt_d      = '0;
            state_d    = S_EMPTY;
         end
         default: begin
            hold_clear = 1'b1;
            cnt_d      = '0;
            state_d    = S_EMPTY;
         end
      endcase
   end

   // Write-port mux, WB stall and MDU ready; everything quiet during reset.
   always_comb begin
      rf_we     = 1'b0;
      rf_wr     = '0;
      rf_wd     = '0;
      wb_stall  = 1'b0;
      mdu_ready = 1'b0;
      if (!rst) begin
         case (state_q)
            S_EMPTY: begin
               mdu_ready = 1'b1;
               if (pipe_req) begin
                  rf_we = 1'b1;
                  rf_wr = pipe_wr;
                  rf_wd = pipe_wd;
               end else if (mdu_req) begin
                  rf_we = 1'b1;
                  rf_wr = mdu_wr;
                  rf_wd = mdu_wd;
               end
            end
            S_PEND: begin
               rf_we = 1'b1;
               if (pipe_req) begin
                  rf_wr = pipe_wr;
                  rf_wd = pipe_wd;
               end else begin
                  rf_wr = hold_wr;
                  rf_wd = hold_wd;
               end
            end
            S_FORCE: begin
               rf_we    = 1'b1;
               rf_wr    = hold_wr;
               rf_wd    = hold_wd;
               wb_stall = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign pend_valid = hold_valid;
   assign pend_wr    = hold_wr;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by
// random traffic, checked cycle by cycle against a reference model.
module tb_wb_port_arbiter;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int MAX_WAIT = 4;
   // {chk_pend_wr, rf_we, rf_wr, rf_wd, wb_stall, mdu_ready, pend_valid, pend_wr}
   localparam int W = 1 + 1 + ADDR_W + DATA_W + 1 + 1 + 1 + ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pipe_we = 1'b0;
   logic [ADDR_W-1:0] pipe_wr = '0;
   logic [DATA_W-1:0] pipe_wd = '0;
   logic              mdu_valid = 1'b0;
   logic              mdu_ready;
   logic [ADDR_W-1:0] mdu_wr = '0;
   logic [DATA_W-1:0] mdu_wd = '0;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_wr;
   logic [DATA_W-1:0] rf_wd;
   logic              wb_stall;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_wr;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   // Reference model: pending MDU result and how many cycles it was denied.
   logic              m_pv = 1'b0;
   logic [ADDR_W-1:0] m_pw = '0;
   logic [DATA_W-1:0] m_pd = '0;
   int                m_age = 0;
   logic              last_stall = 1'b0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   wb_port_arbiter #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pipe_we    (pipe_we),
      .pipe_wr    (pipe_wr),
      .pipe_wd    (pipe_wd),
      .mdu_valid  (mdu_valid),
      .mdu_ready  (mdu_ready),
      .mdu_wr     (mdu_wr),
      .mdu_wd     (mdu_wd),
      .rf_we      (rf_we),
      .rf_wr      (rf_wr),
      .rf_wd      (rf_wd),
      .wb_stall   (wb_stall),
      .pend_valid (pend_valid),
      .pend_wr    (pend_wr)
   );

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   // Applies one cycle of inputs and pushes the model's expected outputs.
   task automatic step(input logic r, input logic pwe, input logic [ADDR_W-1:0] pwr,
                       input logic [DATA_W-1:0] pwd, input logic mv,
                       input logic [ADDR_W-1:0] mwr, input logic [DATA_W-1:0] mwd);
      logic              p_req, m_req, chk, e_we, e_st, e_rdy, e_pv;
      logic [ADDR_W-1:0] e_wr, e_pw;
      logic [DATA_W-1:0] e_wd;
      @(posedge clk);
      #1;
      rst = r; pipe_we = pwe; pipe_wr = pwr; pipe_wd = pwd;
      mdu_valid = mv; mdu_wr = mwr; mdu_wd = mwd;
      p_req = pwe && (pwr != 0);
      m_req = mv && (mwr != 0);
      chk = 1'b0; e_we = 1'b0; e_st = 1'b0; e_rdy = 1'b0; e_pv = 1'b0;
      e_wr = '0; e_pw = '0; e_wd = '0;
      if (r) begin
         m_pv = 1'b0; m_pw = '0; m_age = 0;
         chk = 1'b1;
      end else if (!m_pv) begin
         e_rdy = 1'b1;
         if (p_req) begin
            e_we = 1'b1; e_wr = pwr; e_wd = pwd;
            if (m_req && (mwr != pwr)) begin
               m_pv = 1'b1; m_pw = mwr; m_pd = mwd; m_age = 0;
            end
         end else if (m_req) begin
            e_we = 1'b1; e_wr = mwr; e_wd = mwd;
         end
      end else begin
         e_pv = 1'b1; chk = 1'b1; e_pw = m_pw; e_we = 1'b1;
         if (m_age == MAX_WAIT) begin
            e_wr = m_pw; e_wd = m_pd; e_st = 1'b1; m_pv = 1'b0;
         end else if (!p_req) begin
            e_wr = m_pw; e_wd = m_pd; m_pv = 1'b0;
         end else if (pwr == m_pw) begin
            e_wr = pwr; e_wd = pwd; m_pv = 1'b0;
         end else begin
            e_wr = pwr; e_wd = pwd; m_age++;
         end
      end
      last_stall = e_st;
      exp_q.push_back({chk, e_we, e_wr, e_wd, e_st, e_rdy, e_pv, e_pw});
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0]      e;
      logic              e_chk, e_we, e_st, e_rdy, e_pv;
      logic [ADDR_W-1:0] e_wr, e_pw;
      logic [DATA_W-1:0] e_wd;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         {e_chk, e_we, e_wr, e_wd, e_st, e_rdy, e_pv, e_pw} = e;
         check("rf_we", DATA_W'(rf_we), DATA_W'(e_we));
         if (e_we) begin
            check("rf_wr", DATA_W'(rf_wr), DATA_W'(e_wr));
            check("rf_wd", rf_wd, e_wd);
         end
         check("wb_stall", DATA_W'(wb_stall), DATA_W'(e_st));
         check("mdu_ready", DATA_W'(mdu_ready), DATA_W'(e_rdy));
         check("pend_valid", DATA_W'(pend_valid), DATA_W'(e_pv));
         if (e_chk) check("pend_wr", DATA_W'(pend_wr), DATA_W'(e_pw));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic              hw;
      logic [ADDR_W-1:0] hr;
      logic [DATA_W-1:0] hd;

      // Reset state
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 3, 32'h3, 1, 4, 32'h4);
      step(0, 0, 0, 0, 0, 0, 0);

      // Bypass
      step(0, 0, 0, 0, 1, 7, 32'h1234);

      // Conflict then drain
      step(0, 1, 3, 32'h11, 1, 9, 32'h99);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // Starvation: four denials, forced drain, then the held WB write
      step(0, 1, 3, 32'h11, 1, 9, 32'h99);
      for (int i = 1; i <= 4; i++) step(0, 1, ADDR_W'(i), 32'h100 + i, 0, 0, 0);
      step(0, 1, 5, 32'h105, 0, 0, 0);
      step(0, 1, 5, 32'h105, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // WAW drop of the buffered result
      step(0, 1, 3, 32'h11, 1, 9, 32'h99);
      step(0, 1, 9, 32'h42, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // x0 handling
      step(0, 1, 0, 32'h77, 1, 4, 32'h44);
      step(0, 0, 0, 0, 1, 0, 32'h55);

      // Reset while x5 is buffered; x5 must never be written
      step(0, 1, 3, 32'h11, 1, 5, 32'hDEAD_BEEF);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // Random traffic; a stalled WB write is re-presented next cycle
      hw = 1'b0; hr = '0; hd = '0;
      for (int n = 0; n < 600; n++) begin
         logic r;
         r = ($urandom_range(0, 199) == 0);
         if (!last_stall) begin
            hw = ($urandom_range(0, 3) != 0);
            hr = ADDR_W'($urandom_range(0, 7));
            hd = $urandom;
         end
         step(r, hw, hr, hd, 1'($urandom_range(0, 1)),
              ADDR_W'($urandom_range(0, 7)), $urandom);
      end

      @(negedge clk);
      #1;
      check("queue_drained", DATA_W'(exp_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Arbitrates the single register-file write port between the in-order pipeline writeback (the WB-selected value from alu_c / pc4 / imm) and results returning from the multi-cycle multiply/divide unit (MDU).
- The pipeline has priority.
- A displaced MDU result is parked in a one-entry hold buffer.
- A starvation counter forces the buffered result through by stalling WB for one cycle.
- Sits between the WB stage, the MDU and the register file. It also exports the pending destination to the hazard unit.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.
- MAX_WAIT, 4, consecutive denied cycles before a forced MDU grant; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pipe_we  in  1  WB stage write enable.
- pipe_wr  in  ADDR_W  WB stage destination register.
- pipe_wd  in  DATA_W  WB stage write data (WD select output).
- mdu_valid  in  1  MDU result valid.
- mdu_ready  out  1  arbiter can accept an MDU result.
- mdu_wr  in  ADDR_W  MDU destination register.
- mdu_wd  in  DATA_W  MDU result data.
- rf_we  out  1  register-file write enable.
- rf_wr  out  ADDR_W  register-file write address.
- rf_wd  out  DATA_W  register-file write data.
- wb_stall  out  1  hold the WB stage; its write is retried next cycle.
- pend_valid  out  1  hold buffer occupied.
- pend_wr  out  ADDR_W  destination register held in the buffer.

Behaviour:
- Request definitions:
  - pipe_req = pipe_we && pipe_wr != 0.
  - mdu_req = mdu_valid && mdu_wr != 0.
  - An MDU handshake (mdu_valid && mdu_ready) with mdu_wr == 0 is accepted and discarded.
- rf_* and wb_stall are combinational from state and inputs, so a write lands at the same clock edge. Buffer, counter and state are registered.
- States: S_EMPTY, S_PEND, S_FORCE.
- Reset (async): state=S_EMPTY, buffer invalid, cnt=0, pend_wr=0. While rst is high, rf_we=0, mdu_ready=0, wb_stall=0, pend_valid=0. A buffered result present at reset is lost.
- S_EMPTY (mdu_ready=1):
  - pipe_req only: rf <= pipe.
  - mdu_req only: direct bypass, rf <= mdu, no buffering.
  - Both, different registers: rf <= pipe; capture mdu_wr/mdu_wd; cnt<=0; go S_PEND.
  - Both, same register: rf <= pipe; MDU result discarded (pipeline write is younger, guaranteed by the hazard unit); stay.
  - Neither: rf_we=0.
- S_PEND (mdu_ready=0, pend_valid=1):
  - No pipe_req: rf <= buffer; go S_EMPTY.
  - pipe_req with pipe_wr == pend_wr: rf <= pipe; buffer dropped as stale (WAW); go S_EMPTY.
  - pipe_req otherwise: rf <= pipe; cnt<=cnt+1. If cnt == MAX_WAIT-1, go S_FORCE.
- S_FORCE (mdu_ready=0, pend_valid=1):
  - rf <= buffer; wb_stall=1 regardless of pipe_req; go S_EMPTY; cnt<=0.
  - The pipeline holds its WB instruction, and that write completes in the next cycle.
- Invariants:
  - At most one rf write per cycle.
  - rf_we never asserts with rf_wr == 0.
  - wb_stall is asserted only in S_FORCE.
  - Maximum MDU wait is MAX_WAIT+1 cycles after acceptance.
- Counter is 4 bits and saturates; it never wraps because S_FORCE is always reached first.
- Unused rf_wr/rf_wd are don't-care when rf_we=0; the bench checks them only when rf_we=1.

Decomposition:
- Shared package (wb_pkg) holds:
  - state encoding constants S_EMPTY/S_PEND/S_FORCE;
  - REG_ZERO (5'd0);
  - MAX_WAIT default.
- The WB_ALU/WB_PC4/WB_EXT select codes stay in the existing shared defines.
- One natural sub-module: wb_hold_reg, the one-entry buffer (valid, wr, wd) with load/clear and async reset. The FSM and counter stay in the top.

Test Plan:
1. Reset mid-PEND: buffer x5=0xDEAD_BEEF held, assert rst -> pend_valid=0, rf_we=0, mdu_ready=0 immediately; after release, state is S_EMPTY and x5 is never written.
2. Bypass: S_EMPTY, pipe_we=0, mdu_valid=1, mdu_wr=7, mdu_wd=0x1234 -> same cycle rf_we=1, rf_wr=7, rf_wd=0x1234; pend_valid stays 0.
3. Conflict then drain: pipe x3=0x11 and mdu x9=0x99 together -> rf writes x3; next cycle pipe_we=0 -> rf writes x9=0x99, mdu_ready returns to 1.
4. Starvation, MAX_WAIT=4: mdu x9 buffered, pipe writes x1..x4 on consecutive cycles -> cycle 5 wb_stall=1, rf writes x9; cycle 6 the held pipe write completes.
5. WAW drop: buffer x9=0x99, pipe writes x9=0x42 -> rf writes x9=0x42, pend_valid falls next cycle, 0x99 never written.
6. x0 handling: pipe_we=1, pipe_wr=0 with mdu x4 valid -> bypass writes x4. A separate mdu_wr=0 result is accepted with rf_we=0.
